// File: rtl/ct_wrr_sched.sv
// ct_wrr_sched: packet-granular weighted round-robin scheduler.
//
// This block drives the select lines of an N-input merge mux. A grant is
// held until a packet boundary. The granted input may send up to its weight
// in consecutive packets, and then the grant rotates to the next requester.
// Each input's weight can be changed at runtime through a small write port.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   i_req[NI]           per-input request (a beat is staged)
//   i_xfer              a beat from the granted input was accepted this cycle
//   i_eop               the accepted beat is end-of-packet
//   i_cfg_wr            weight write strobe
//   i_cfg_idx           input index to write (out-of-range writes are dropped)
//   i_cfg_weight        new weight (0 behaves as 1)
//   o_sel               granted input index (mux select)
//   o_grant[NI]         one-hot grant, all-zero when no grant is held
//   o_grant_valid       a grant is currently held
//   o_credit            packets left in this turn, including the one in flight
module ct_wrr_sched #(
  parameter int NI     = 4,
  parameter int NIBITS = 2,
  parameter int WBITS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NI-1:0]     i_req,
  input  logic              i_xfer,
  input  logic              i_eop,
  input  logic              i_cfg_wr,
  input  logic [NIBITS-1:0] i_cfg_idx,
  input  logic [WBITS-1:0]  i_cfg_weight,
  output logic [NIBITS-1:0] o_sel,
  output logic [NI-1:0]     o_grant,
  output logic              o_grant_valid,
  output logic [WBITS-1:0]  o_credit
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state;
  logic [NIBITS-1:0] last;
  logic [WBITS-1:0]  weight [NI];

  logic [NIBITS-1:0] scan_base;
  logic [NIBITS-1:0] next_idx;
  logic              found;
  logic [WBITS-1:0]  next_credit;
  int                cand;

  // The round-robin scan starts one position past the most recently served
  // input. While a grant is held, that position is the current holder. This
  // gives the holder the lowest priority, and it still wins when it is the
  // only requester.
  always_comb begin
    scan_base = (state == HOLD) ? o_sel : last;
    next_idx  = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NI; k++) begin
      cand = (int'(scan_base) + k) % NI;
      if (!found && i_req[cand]) begin
        found    = 1'b1;
        next_idx = NIBITS'(cand);
      end
    end
    next_credit = (weight[next_idx] == '0) ? WBITS'(1) : weight[next_idx];
  end

  // Scheduler FSM. All outputs are registered here. The credit counts
  // packets, so only an end-of-packet beat can move it. A turn continues
  // only while credit remains and the holder still requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      o_sel         <= '0;
      o_grant       <= '0;
      o_grant_valid <= 1'b0;
      o_credit      <= '0;
      last          <= NIBITS'(NI - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state         <= HOLD;
            o_sel         <= next_idx;
            o_grant       <= NI'(1) << next_idx;
            o_grant_valid <= 1'b1;
            o_credit      <= next_credit;
          end
        end
        HOLD: begin
          if (i_xfer && i_eop) begin
            if (o_credit > WBITS'(1) && i_req[o_sel]) begin
              o_credit <= o_credit - WBITS'(1);
            end else begin
              last <= o_sel;
              if (found) begin
                o_sel    <= next_idx;
                o_grant  <= NI'(1) << next_idx;
                o_credit <= next_credit;
              end else begin
                state         <= IDLE;
                o_grant       <= '0;
                o_grant_valid <= 1'b0;
                o_credit      <= '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Weight registers. A load in the same cycle as a write to that index
  // reads the old value, because the new value only exists after this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NI; i++) weight[i] <= WBITS'(1);
    end else if (i_cfg_wr && (32'(i_cfg_idx) < 32'(NI))) begin
      weight[i_cfg_idx] <= i_cfg_weight;
    end
  end

endmodule

// File: tb/tb_ct_wrr_sched.sv
// tb_ct_wrr_sched: self-checking bench for ct_wrr_sched.
//
// A behavioural model tracks the grant holder, the packets used in the
// current turn and the configured weights. Every falling edge compares the
// DUT outputs with that model. Directed scenarios add literal expectations,
// and a randomized phase follows them.
module tb_ct_wrr_sched;

  localparam int NI     = 4;
  localparam int NIBITS = 2;
  localparam int WBITS  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NI-1:0]     i_req = '0;
  logic              i_xfer = 1'b0;
  logic              i_eop = 1'b0;
  logic              i_cfg_wr = 1'b0;
  logic [NIBITS-1:0] i_cfg_idx = '0;
  logic [WBITS-1:0]  i_cfg_weight = '0;
  logic [NIBITS-1:0] o_sel;
  logic [NI-1:0]     o_grant;
  logic              o_grant_valid;
  logic [WBITS-1:0]  o_credit;

  int n_checks = 0;
  int n_fail   = 0;

  ct_wrr_sched #(.NI(NI), .NIBITS(NIBITS), .WBITS(WBITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req        (i_req),
    .i_xfer       (i_xfer),
    .i_eop        (i_eop),
    .i_cfg_wr     (i_cfg_wr),
    .i_cfg_idx    (i_cfg_idx),
    .i_cfg_weight (i_cfg_weight),
    .o_sel        (o_sel),
    .o_grant      (o_grant),
    .o_grant_valid(o_grant_valid),
    .o_credit     (o_credit)
  );

  always #5 clk = ~clk;

  // Model state: the holder, the packets already sent in this turn, and the
  // weight captured when the turn began.
  bit m_valid;
  int m_sel, m_used, m_turn_w, m_last;
  int m_w [NI];

  function automatic int eff(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int rr_pick(input logic [NI-1:0] req, input int after);
    for (int d = 1; d <= NI; d++) begin
      if (req[(after + d) % NI]) return (after + d) % NI;
    end
    return -1;
  endfunction

  function automatic int model_credit();
    return m_valid ? (m_turn_w - m_used) : 0;
  endfunction

  task automatic model_load(input int n);
    m_valid  = 1'b1;
    m_sel    = n;
    m_used   = 0;
    m_turn_w = eff(m_w[n]);
  endtask

  task automatic model_step();
    int mc, mn;
    if (reset) begin
      m_valid  = 1'b0;
      m_sel    = 0;
      m_used   = 0;
      m_turn_w = 0;
      m_last   = NI - 1;
      for (int i = 0; i < NI; i++) m_w[i] = 1;
    end else begin
      mc = model_credit();
      if (!m_valid) begin
        mn = rr_pick(i_req, m_last);
        if (mn >= 0) model_load(mn);
      end else if (i_xfer && i_eop) begin
        if (mc > 1 && i_req[m_sel]) begin
          m_used++;
        end else begin
          m_last = m_sel;
          mn = rr_pick(i_req, m_sel);
          if (mn >= 0) model_load(mn);
          else m_valid = 1'b0;
        end
      end
      if (i_cfg_wr && int'(i_cfg_idx) < NI) m_w[i_cfg_idx] = int'(i_cfg_weight);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      model_step();
    end
  end

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks every cycle against the model.
  initial begin
    forever begin
      @(negedge clk);
      check_val("model_valid", int'(o_grant_valid), int'(m_valid));
      if (m_valid) check_val("model_sel", int'(o_sel), m_sel);
      check_val("model_grant", int'(o_grant), m_valid ? (1 << m_sel) : 0);
      check_val("model_credit", int'(o_credit), model_credit());
    end
  end

  task automatic check_output(input string name, input int v, input int s, input int c);
    check_val({name, "_valid"}, int'(o_grant_valid), v);
    if (v != 0) check_val({name, "_sel"}, int'(o_sel), s);
    check_val({name, "_grant"}, int'(o_grant), (v != 0) ? (1 << s) : 0);
    check_val({name, "_credit"}, int'(o_credit), c);
  endtask

  task automatic apply_stimulus(input logic [NI-1:0] req, input logic xfer, input logic eop);
    #1;
    i_req    = req;
    i_xfer   = xfer;
    i_eop    = eop;
    i_cfg_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic cfg_write(input int idx, input int w);
    #1;
    i_req        = '0;
    i_xfer       = 1'b0;
    i_eop        = 1'b0;
    i_cfg_wr     = 1'b1;
    i_cfg_idx    = NIBITS'(idx);
    i_cfg_weight = WBITS'(w);
    @(negedge clk);
    i_cfg_wr = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    reset  = 1'b1;
    i_req  = '0;
    i_xfer = 1'b0;
    i_eop  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  int exp_sel2 [8] = '{0, 0, 0, 1, 2, 2, 3, 0};
  int exp_cr2  [8] = '{3, 2, 1, 1, 2, 1, 1, 3};

  initial begin
    logic [NI-1:0] rq;

    // Reset values, then plain round-robin with unit weights.
    do_reset();
    check_output("reset", 0, 0, 0);
    check_val("reset_sel", int'(o_sel), 0);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(4'b1111, 1'b1, 1'b1);
      check_output("rr_unit", 1, i % 4, 1);
    end

    // Weights {3,1,2,1}.
    do_reset();
    cfg_write(0, 3);
    cfg_write(1, 1);
    cfg_write(2, 2);
    cfg_write(3, 1);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(4'b1111, 1'b1, 1'b1);
      check_output("wrr", 1, exp_sel2[i], exp_cr2[i]);
    end

    // Packet lock across a dropped request, then a re-grant to the same input.
    do_reset();
    cfg_write(1, 2);
    apply_stimulus(4'b0010, 1'b0, 1'b0);
    check_output("lock_grant", 1, 1, 2);
    apply_stimulus(4'b0010, 1'b1, 1'b0);
    check_output("lock_b1", 1, 1, 2);
    apply_stimulus(4'b0000, 1'b1, 1'b0);
    check_output("lock_b2", 1, 1, 2);
    apply_stimulus(4'b0010, 1'b1, 1'b0);
    check_output("lock_b3", 1, 1, 2);
    apply_stimulus(4'b0010, 1'b1, 1'b1);
    check_output("lock_eop1", 1, 1, 1);
    for (int i = 0; i < 3; i++) apply_stimulus(4'b0010, 1'b1, 1'b0);
    apply_stimulus(4'b0010, 1'b1, 1'b1);
    check_output("lock_regrant", 1, 1, 2);

    // Early turn end when the holder stops requesting at its eop.
    do_reset();
    cfg_write(0, 4);
    apply_stimulus(4'b0101, 1'b0, 1'b0);
    check_output("early_grant", 1, 0, 4);
    apply_stimulus(4'b0100, 1'b1, 1'b1);
    check_output("early_move", 1, 2, 1);

    // A weight of 0 acts as 1, and the grant is released when no one requests.
    do_reset();
    cfg_write(3, 0);
    apply_stimulus(4'b1000, 1'b0, 1'b0);
    check_output("w0_grant", 1, 3, 1);
    apply_stimulus(4'b0000, 1'b1, 1'b1);
    check_output("w0_idle", 0, 0, 0);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    cfg_write(0, 3);
    apply_stimulus(4'b0001, 1'b0, 1'b0);
    check_output("ar_grant", 1, 0, 3);
    apply_stimulus(4'b0001, 1'b1, 1'b1);
    check_output("ar_eop", 1, 0, 2);
    apply_stimulus(4'b0001, 1'b1, 1'b0);
    check_output("ar_mid", 1, 0, 2);
    #1 reset = 1'b1;
    #2;
    check_output("ar_async", 0, 0, 0);
    check_val("ar_async_sel", int'(o_sel), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    apply_stimulus(4'b0001, 1'b0, 1'b0);
    check_output("ar_after", 1, 0, 1);

    // Randomized traffic, including weight writes and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        rq = ($urandom_range(0, 9) == 0) ? '0 : NI'($urandom);
        #1;
        i_req        = rq;
        i_xfer       = ($urandom_range(0, 3) != 0);
        i_eop        = ($urandom_range(0, 2) == 0);
        i_cfg_wr     = ($urandom_range(0, 7) == 0);
        i_cfg_idx    = NIBITS'($urandom);
        i_cfg_weight = WBITS'($urandom);
        @(negedge clk);
      end
    end

    #1;
    i_req    = '0;
    i_cfg_wr = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
